// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding and legal parameter ranges shared by the UART receive controller
// and its bit sampler.
package uart_rx_pkg;

  // State encoding (3 bits)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    PARITY  = ST_PARITY,
    STOP    = ST_STOP,
    WAIT_HI = ST_WAIT_HI
  } rx_state_e;

  // Legal parameter ranges
  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Oversampling must be a power of two so the edge counter wraps cleanly.
  function automatic bit legal_prescale(input int p);
    return (p == 8) || (p == 16) || (p == 32);
  endfunction

  function automatic bit legal_cfg(input int dw, input int p, input int sb);
    return (dw >= DATA_W_MIN) && (dw <= DATA_W_MAX) &&
           (sb >= STOP_BITS_MIN) && (sb <= STOP_BITS_MAX) &&
           legal_prescale(p);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority vote around the bit centre.
// bit_dec_o marks the decision cycle (bit_val_o valid), bit_end_o the last cycle of a bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic rx_i,
  output logic bit_val_o,
  output logic bit_dec_o,
  output logic bit_end_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] E_S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] E_S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] E_DEC  = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] E_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] edge_cnt_q, edge_cnt_d;
  logic [1:0]    smp_q, smp_d;

  // Next counter value and capture of the two early samples
  always_comb begin
    edge_cnt_d = clr_i ? '0 : ((edge_cnt_q == E_LAST) ? '0 : edge_cnt_q + 1'b1);
    smp_d      = smp_q;
    if (edge_cnt_q == E_S0) smp_d[0] = rx_i;
    if (edge_cnt_q == E_S1) smp_d[1] = rx_i;
  end

  // Counter and sample registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  // Third sample is the live input in the decision cycle
  assign bit_val_o = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_i) | (smp_q[1] & rx_i);
  assign bit_dec_o = (edge_cnt_q == E_DEC);
  assign bit_end_o = (edge_cnt_q == E_LAST);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame controller (start detect, deserialise, optional
// parity, 1/2 stop bits, per-frame status pulses).
// Optional feature: define UART_RX_BREAK_DET_EN to report all-zero frames as break_det.
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PRESCALE  = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              par_en,
  input  logic              par_odd,
  output logic [DATA_W-1:0] p_data,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err,
  output logic              strt_glitch,
  output logic              break_det,
  output logic              busy
);

  if (!legal_cfg(DATA_W, PRESCALE, STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_frame_ctrl: illegal DATA_W/PRESCALE/STOP_BITS");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d, p_data_q, p_data_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic              perr_q, perr_d, serr_q, serr_d;
  logic              data_valid_q, data_valid_d, par_err_q, par_err_d;
  logic              stp_err_q, stp_err_d, strt_glitch_q, strt_glitch_d;
  logic              bit_val, bit_dec, bit_end, clr;
`ifdef UART_RX_BREAK_DET_EN
  logic              all_zero_q, all_zero_d, break_det_q, break_det_d;
`endif

  // Counter runs only while a frame is being received
  assign clr = (state_d == IDLE) || (state_d == WAIT_HI);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .rx_i      (rx_in),
    .bit_val_o (bit_val),
    .bit_dec_o (bit_dec),
    .bit_end_o (bit_end)
  );

  // Next-state, frame bookkeeping and status pulse generation
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    p_data_d      = p_data_q;
    bit_cnt_d     = bit_cnt_q;
    par_en_d      = par_en_q;
    par_odd_d     = par_odd_q;
    perr_d        = perr_q;
    serr_d        = serr_q;
    data_valid_d  = 1'b0;
    par_err_d     = 1'b0;
    stp_err_d     = 1'b0;
    strt_glitch_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    all_zero_d    = all_zero_q;
    break_det_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          bit_cnt_d = '0;
          par_en_d  = par_en;
          par_odd_d = par_odd;
          perr_d    = 1'b0;
          serr_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = 1'b1;
`endif
        end
      end
      START: begin
        if (bit_dec && bit_val) begin
          strt_glitch_d = 1'b1;
          state_d       = IDLE;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_dec) begin
          shift_d = {bit_val, shift_q[DATA_W-1:1]};
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = all_zero_q & ~bit_val;
`endif
        end
        if (bit_end) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_dec) begin
          perr_d = bit_val ^ (^shift_q) ^ par_odd_q;
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = all_zero_q & ~bit_val;
`endif
        end
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_dec) begin
          serr_d = serr_q | ~bit_val;
`ifdef UART_RX_BREAK_DET_EN
          all_zero_d = all_zero_q & ~bit_val;
`endif
          // Final stop bit closes the frame at its decision point
          if (bit_cnt_q == LAST_STOP) begin
`ifdef UART_RX_BREAK_DET_EN
            if (all_zero_d) begin
              break_det_d = 1'b1;
              state_d     = WAIT_HI;
            end else
`endif
            begin
              par_err_d = perr_q;
              stp_err_d = serr_d;
              if (!perr_q && !serr_d) begin
                data_valid_d = 1'b1;
                p_data_d     = shift_q;
              end
              state_d = serr_d ? WAIT_HI : IDLE;
            end
          end
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      WAIT_HI: begin
        if (rx_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      p_data_q      <= '0;
      bit_cnt_q     <= '0;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      perr_q        <= 1'b0;
      serr_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      strt_glitch_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q    <= 1'b0;
      break_det_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      p_data_q      <= p_data_d;
      bit_cnt_q     <= bit_cnt_d;
      par_en_q      <= par_en_d;
      par_odd_q     <= par_odd_d;
      perr_q        <= perr_d;
      serr_q        <= serr_d;
      data_valid_q  <= data_valid_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      strt_glitch_q <= strt_glitch_d;
`ifdef UART_RX_BREAK_DET_EN
      all_zero_q    <= all_zero_d;
      break_det_q   <= break_det_d;
`endif
    end
  end

  assign p_data      = p_data_q;
  assign data_valid  = data_valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = strt_glitch_q;
  assign busy        = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_det   = break_det_q;
`else
  assign break_det   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: DUT1 (STOP_BITS=1) and DUT2 (STOP_BITS=2), P=8, DATA_W=8.
// Expected status pulses are queued when a frame is driven and checked by per-DUT monitors.
module tb_uart_rx_frame_ctrl;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1, rx2 = 1'b1, par_en = 1'b0, par_odd = 1'b0;
  logic [7:0] p_data, p_data2;
  logic       data_valid, par_err, stp_err, strt_glitch, break_det, busy;
  logic       data_valid2, par_err2, stp_err2, strt_glitch2, break_det2, busy2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         kind;   // 0 data_valid, 1 par_err, 2 stp_err, 3 strt_glitch, 4 break_det
    int         at;
    logic [7:0] data;
  } ev_t;

  ev_t exp1[$];
  ev_t exp2[$];
  ev_t e1, e2;
  logic [4:0] pv1, pv2;

  uart_rx_frame_ctrl #(.DATA_W(8), .PRESCALE(P), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx), .par_en(par_en), .par_odd(par_odd),
    .p_data(p_data), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
    .strt_glitch(strt_glitch), .break_det(break_det), .busy(busy));

  uart_rx_frame_ctrl #(.DATA_W(8), .PRESCALE(P), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rx_in(rx2), .par_en(par_en), .par_odd(par_odd),
    .p_data(p_data2), .data_valid(data_valid2), .par_err(par_err2), .stp_err(stp_err2),
    .strt_glitch(strt_glitch2), .break_det(break_det2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int k, input int at, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.data = d;
    return e;
  endfunction

  // DUT1 monitor: every status pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst) begin
      pv1 = {break_det, strt_glitch, stp_err, par_err, data_valid};
      for (int k = 0; k < 5; k++) begin
        if (pv1[k]) begin
          total++;
          if (exp1.size() == 0) begin
            bad++;
            $display("FAIL mon1_unexpected kind=%0d cyc=%0d data=%02h required none", k, cyc, p_data);
          end else begin
            e1 = exp1.pop_front();
            if (e1.kind !== k || e1.at !== cyc || (k == 0 && p_data !== e1.data)) begin
              bad++;
              $display("FAIL mon1_event got kind=%0d cyc=%0d data=%02h required kind=%0d cyc=%0d data=%02h",
                       k, cyc, p_data, e1.kind, e1.at, e1.data);
            end else begin
              $display("rx1 event kind=%0d cyc=%0d data=%02h", k, cyc, p_data);
            end
          end
        end
      end
    end
  end

  // DUT2 monitor
  always @(negedge clk) begin
    if (rst) begin
      pv2 = {break_det2, strt_glitch2, stp_err2, par_err2, data_valid2};
      for (int k = 0; k < 5; k++) begin
        if (pv2[k]) begin
          total++;
          if (exp2.size() == 0) begin
            bad++;
            $display("FAIL mon2_unexpected kind=%0d cyc=%0d data=%02h required none", k, cyc, p_data2);
          end else begin
            e2 = exp2.pop_front();
            if (e2.kind !== k || e2.at !== cyc || (k == 0 && p_data2 !== e2.data)) begin
              bad++;
              $display("FAIL mon2_event got kind=%0d cyc=%0d data=%02h required kind=%0d cyc=%0d data=%02h",
                       k, cyc, p_data2, e2.kind, e2.at, e2.data);
            end else begin
              $display("rx2 event kind=%0d cyc=%0d data=%02h", k, cyc, p_data2);
            end
          end
        end
      end
    end
  end

  // All tasks start and end one time unit after a rising edge
  task automatic drive_bit(input int line, input logic b);
    if (line == 0) rx = b;
    else rx2 = b;
    repeat (P) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx  = 1'b1;
    rx2 = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit with_par,
                            input logic par_bit, input logic [1:0] stops, input int nstop,
                            input bit flip);
    drive_bit(line, 1'b0);
    if (flip) begin
      par_en  = ~par_en;
      par_odd = ~par_odd;
    end
    for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
    if (with_par) drive_bit(line, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(line, stops[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({data_valid, par_err, stp_err, strt_glitch, break_det} !== 5'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b required=00000",
               {data_valid, par_err, stp_err, strt_glitch, break_det});
    end
    total++;
    if (p_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_p_data got=%02h required=00", p_data);
    end
    rst = 1'b1;
    idle(4);
    total++;
    if (busy !== 1'b0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b%b required=00", busy, busy2);
    end
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp1.size() != 0 || exp2.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_pulses got pending=%0d/%0d required=0/0", name, exp1.size(), exp2.size());
      exp1.delete();
      exp2.delete();
    end
  endtask

  task automatic test_frame_ok();
    exp1.push_back(mk(0, cyc + 78, 8'hA5));
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    idle(10);
    check_drained("frame_ok");
    total++;
    if (p_data !== 8'hA5 || busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_ok_hold got p_data=%02h busy=%b required p_data=a5 busy=0", p_data, busy);
    end
  endtask

  task automatic test_parity_err();
    par_en  = 1'b1;
    par_odd = 1'b0;
    exp1.push_back(mk(1, cyc + 86, 8'h00));
    send_frame(0, 8'h03, 1'b1, 1'b1, 2'b11, 1, 1'b0);
    idle(10);
    check_drained("parity_err");
    total++;
    if (p_data !== 8'hA5) begin
      bad++;
      $display("FAIL parity_err_p_data got=%02h required=a5", p_data);
    end
  endtask

  task automatic test_parity_latch();
    par_en  = 1'b1;
    par_odd = 1'b1;
    exp1.push_back(mk(0, cyc + 86, 8'h07));
    send_frame(0, 8'h07, 1'b1, 1'b0, 2'b11, 1, 1'b1);
    idle(10);
    check_drained("parity_latch");
    par_en  = 1'b0;
    par_odd = 1'b0;
  endtask

  task automatic test_glitch();
    exp1.push_back(mk(3, cyc + 6, 8'h00));
    for (int c = 0; c < 24; c++) begin
      rx = (c < 2) ? 1'b0 : 1'b1;
      if (c == 3) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL glitch_busy_hi got=%b required=1", busy);
        end
      end
      if (c == 7) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL glitch_busy_lo got=%b required=0", busy);
        end
      end
      @(posedge clk);
      #1;
    end
    check_drained("glitch");
  endtask

  task automatic test_stop2_stuck();
    exp2.push_back(mk(2, cyc + 86, 8'h00));
    send_frame(1, 8'h3C, 1'b0, 1'b0, 2'b01, 2, 1'b0);
    rx2 = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (busy2 !== 1'b1) begin
      bad++;
      $display("FAIL stuck_busy got=%b required=1", busy2);
    end
    check_drained("stuck");
    idle(3);
    total++;
    if (busy2 !== 1'b0) begin
      bad++;
      $display("FAIL stuck_release_busy got=%b required=0", busy2);
    end
    exp2.push_back(mk(0, cyc + 86, 8'h96));
    send_frame(1, 8'h96, 1'b0, 1'b0, 2'b11, 2, 1'b0);
    idle(10);
    check_drained("stop2_ok");
  endtask

  task automatic test_back_to_back();
    exp1.push_back(mk(0, cyc + 78, 8'h11));
    exp1.push_back(mk(0, cyc + 158, 8'h22));
    send_frame(0, 8'h11, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    idle(10);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h5A;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx = d[4];
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    total++;
    if ({data_valid, par_err, stp_err, strt_glitch, break_det, busy} !== 6'b0 || p_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid got pulses/busy=%b p_data=%02h required 000000 00",
               {data_valid, par_err, stp_err, strt_glitch, break_det, busy}, p_data);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(5);
    check_drained("reset_abort");
    exp1.push_back(mk(0, cyc + 78, 8'h5A));
    send_frame(0, 8'h5A, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    idle(10);
    check_drained("after_reset");
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_parity_err();
    test_glitch();
    test_parity_latch();
    test_stop2_stuck();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
